counter_game_master: RTL and testbench
======================================

Name: counter_game_master

Overview:
- Drives the 4-bit multi-mode counter and consumes its result signals.
- Loads the counter (INIT, initial_val) and drives ctrl, either fixed or on an auto-mode schedule.
- Tallies WINNER/LOSER pulses independently and checks GAMEOVER/WHO against its own tallies.
- Runs a match of NUM_GAMES games and reports the outcome and any protocol errors.

Parameters:
- NUM_GAMES, 4: games per match (1..15).
- MODE_HOLD, 8: cycles each ctrl value is held in auto mode (>=1).
- TIMEOUT, 1023: maximum PLAY cycles per game without GAMEOVER before an error is raised.
- LFSR_SEED, 4'b1001: auto-mode LFSR reset value (nonzero).

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a match from IDLE or DONE, ignored elsewhere
- seed_val  in  4  initial count, captured on an accepted start
- ctrl_mode  in  2  fixed ctrl value used when auto_mode=0
- auto_mode  in  1  1 = ctrl taken from LFSR[1:0]; captured on start
- INIT  out  1  counter load strobe
- initial_val  out  4  counter load value
- ctrl  out  2  counter mode
- WINNER  in  1  counter reached 4'hF
- LOSER  in  1  counter reached 4'h0
- GAMEOVER  in  1  counter game end
- WHO  in  2  01 = loser side, 10 = winner side
- busy  out  1  match in progress
- done  out  1  match complete (held)
- win_tally  out  4  WINNER pulses in the current game
- loss_tally  out  4  LOSER pulses in the current game
- games_won  out  4  games ending WHO=10
- games_lost  out  4  games ending WHO=01
- proto_err  out  1  sticky error flag
- err_code  out  3  first error: 1 = WINNER&LOSER together, 2 = early GAMEOVER, 3 = WHO mismatch, 4 = WHO!=0 without GAMEOVER, 5 = timeout

Behaviour:
- Reset (rst=1 at posedge):
  - State=IDLE.
  - All outputs 0, except initial_val=0 and ctrl=0.
  - LFSR=LFSR_SEED.
  - Tallies, game counters and timer=0.
  - rst mid-match aborts immediately with no further INIT.
- States: IDLE, LOAD, PLAY, RECORD, DONE, ERROR.
- IDLE/DONE, start=1:
  - Capture seed_val, ctrl_mode, auto_mode.
  - Clear tallies, games_won, games_lost, proto_err, err_code, done.
  - Go to LOAD.
- LOAD (exactly 1 cycle):
  - INIT=1, initial_val=seed.
  - busy=1 from this cycle until DONE or ERROR.
  - Go to PLAY.
- PLAY, ctrl output:
  - auto_mode=0: ctrl=captured ctrl_mode.
  - auto_mode=1: ctrl=LFSR[1:0]. LFSR (x^4+x^3+1, shift left) advances every MODE_HOLD PLAY cycles; its hold counter resets on LOAD.
- PLAY, tallies:
  - WINNER=1 increments win_tally; LOSER=1 increments loss_tally.
  - Tallies saturate at 15.
  - The timer increments each PLAY cycle.
- PLAY, GAMEOVER=1 checks:
  - Expected WHO is 10 if win_tally==15, else 01 if loss_tally==15.
  - If both tallies are 15, either WHO value is accepted.
  - If neither tally is 15: err 2.
  - If WHO differs from the expected value: err 3.
  - If GAMEOVER and WINNER/LOSER assert in the same cycle, count the pulse first, then check.
- PLAY, other errors:
  - WHO!=0 while GAMEOVER=0: err 4.
  - WINNER=1 and LOSER=1 together: err 1.
  - Timer reaching TIMEOUT: err 5.
- RECORD (1 cycle):
  - Increment games_won or games_lost.
  - Clear tallies and timer.
  - If games_won+games_lost==NUM_GAMES, go to DONE; otherwise return to PLAY with no new INIT (the counter reloads itself).
- DONE:
  - done=1, busy=0, ctrl=0.
  - Tallies and game counts hold.
- ERROR:
  - proto_err=1, err_code holds the first error only, busy=0, ctrl=0.
  - Exit only on rst.
  - Errors detected in the same cycle resolve to the lowest code.
- Counter inputs are ignored outside PLAY.
- start is ignored in LOAD, PLAY, RECORD and ERROR.

Test Plan:
- Single winning game: NUM_GAMES=1, seed=0, ctrl_mode=00, auto=0, stub counter model.
  -> INIT high 1 cycle with initial_val=0; WINNER every 16 cycles; GAMEOVER with WHO=10 at win_tally=15; games_won=1, done=1, proto_err=0.
- Winner-only game: seed=15, ctrl_mode=11.
  -> counter visits only odd values; loss_tally stays 0; win_tally=15 then WHO=10 accepted.
- Early GAMEOVER: stub asserts GAMEOVER with WHO=01 while loss_tally=3.
  -> proto_err=1, err_code=2, state ERROR until rst.
- Simultaneous result pulses: WINNER and LOSER asserted together.
  -> err_code=1. WHO=10 asserted with GAMEOVER=0 -> err_code=4.
- Timeout: TIMEOUT=20, stub never asserts GAMEOVER.
  -> err_code=5 after 20 PLAY cycles.
- Auto mode and reset: auto_mode=1, MODE_HOLD=8.
  -> ctrl changes only on 8-cycle boundaries following the LFSR sequence from 4'b1001.
  -> rst mid-PLAY returns all outputs to 0 on the next edge; a new start yields a fresh single INIT pulse.

Source files
------------

// File: rtl/counter_game_master.sv
// counter_game_master: drives a 4-bit multi-mode counter through a match of
// NUM_GAMES games, tallies its WINNER/LOSER pulses and cross-checks the
// counter's GAMEOVER/WHO report against those tallies.
module counter_game_master #(
   parameter int unsigned NUM_GAMES = 4,
   parameter int unsigned MODE_HOLD = 8,
   parameter int unsigned TIMEOUT   = 1023,
   parameter logic [3:0]  LFSR_SEED = 4'b1001
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] seed_val,
   input  logic [1:0] ctrl_mode,
   input  logic       auto_mode,
   output logic       INIT,
   output logic [3:0] initial_val,
   output logic [1:0] ctrl,
   input  logic       WINNER,
   input  logic       LOSER,
   input  logic       GAMEOVER,
   input  logic [1:0] WHO,
   output logic       busy,
   output logic       done,
   output logic [3:0] win_tally,
   output logic [3:0] loss_tally,
   output logic [3:0] games_won,
   output logic [3:0] games_lost,
   output logic       proto_err,
   output logic [2:0] err_code
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned HW = (MODE_HOLD > 1) ? $clog2(MODE_HOLD) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
      S_RECORD,
      S_DONE,
      S_ERROR
   } state_t;

   state_t state, state_nx;

   logic [3:0]    seed_q;
   logic [1:0]    mode_q;
   logic          auto_q;
   logic [3:0]    lfsr;
   logic [HW-1:0] hold_cnt;
   logic [TW-1:0] timer;
   logic          who_win_q;

   logic [3:0]    win_nx, loss_nx;
   logic [TW-1:0] timer_nx;
   logic          win_full, loss_full, who_ok;
   logic [2:0]    err_nx;
   logic          game_end;
   logic [3:0]    won_nx, lost_nx;
   logic          match_over;
   logic [1:0]    ctrl_play;

   // Play-cycle evaluation: pulses are counted first, then GAMEOVER/WHO are judged
   // against the updated tallies; simultaneous errors resolve to the lowest code.
   always_comb begin
      win_nx    = (WINNER && win_tally != 4'hF) ? win_tally + 4'd1 : win_tally;
      loss_nx   = (LOSER && loss_tally != 4'hF) ? loss_tally + 4'd1 : loss_tally;
      timer_nx  = timer + TW'(1);
      win_full  = (win_nx == 4'hF);
      loss_full = (loss_nx == 4'hF);
      if (win_full && loss_full)
         who_ok = (WHO == 2'b10) || (WHO == 2'b01);
      else if (win_full)
         who_ok = (WHO == 2'b10);
      else
         who_ok = (WHO == 2'b01);

      err_nx = 3'd0;
      if (WINNER && LOSER)
         err_nx = 3'd1;
      else if (GAMEOVER && !win_full && !loss_full)
         err_nx = 3'd2;
      else if (GAMEOVER && !who_ok)
         err_nx = 3'd3;
      else if (!GAMEOVER && WHO != 2'b00)
         err_nx = 3'd4;
      else if (!GAMEOVER && timer_nx == TW'(TIMEOUT))
         err_nx = 3'd5;
      game_end = GAMEOVER && (err_nx == 3'd0);

      won_nx     = who_win_q ? games_won + 4'd1 : games_won;
      lost_nx    = who_win_q ? games_lost : games_lost + 4'd1;
      match_over = ({1'b0, won_nx} + {1'b0, lost_nx}) == 5'(NUM_GAMES);
      ctrl_play  = auto_q ? lfsr[1:0] : mode_q;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE, S_DONE: if (start) state_nx = S_LOAD;
         S_LOAD:         state_nx = S_PLAY;
         S_PLAY: begin
            if (err_nx != 3'd0)
               state_nx = S_ERROR;
            else if (game_end)
               state_nx = S_RECORD;
         end
         S_RECORD:       state_nx = match_over ? S_DONE : S_PLAY;
         S_ERROR:        state_nx = S_ERROR;
         default:        state_nx = S_IDLE;
      endcase
   end

   // Outputs decoded from state; ctrl is only driven while the counter is in use
   always_comb begin
      INIT        = (state == S_LOAD);
      initial_val = (state == S_LOAD) ? seed_q : 4'd0;
      busy        = (state == S_LOAD) || (state == S_PLAY) || (state == S_RECORD);
      ctrl        = busy ? ctrl_play : 2'b00;
      done        = (state == S_DONE);
      proto_err   = (state == S_ERROR);
   end

   // Match datapath: captures, tallies, timer, game counts, first error, LFSR
   always_ff @(posedge clk) begin
      if (rst) begin
         seed_q     <= '0;
         mode_q     <= '0;
         auto_q     <= 1'b0;
         lfsr       <= LFSR_SEED;
         hold_cnt   <= '0;
         timer      <= '0;
         who_win_q  <= 1'b0;
         win_tally  <= '0;
         loss_tally <= '0;
         games_won  <= '0;
         games_lost <= '0;
         err_code   <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  seed_q     <= seed_val;
                  mode_q     <= ctrl_mode;
                  auto_q     <= auto_mode;
                  timer      <= '0;
                  win_tally  <= '0;
                  loss_tally <= '0;
                  games_won  <= '0;
                  games_lost <= '0;
                  err_code   <= '0;
               end
            end
            S_LOAD: begin
               hold_cnt <= '0;
               timer    <= '0;
            end
            S_PLAY: begin
               win_tally  <= win_nx;
               loss_tally <= loss_nx;
               timer      <= timer_nx;
               who_win_q  <= (WHO == 2'b10);
               if (err_nx != 3'd0)
                  err_code <= err_nx;
               if (hold_cnt == HW'(MODE_HOLD - 1)) begin
                  hold_cnt <= '0;
                  lfsr     <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            S_RECORD: begin
               games_won  <= won_nx;
               games_lost <= lost_nx;
               win_tally  <= '0;
               loss_tally <= '0;
               timer      <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_game_master.sv
// Directed bench for counter_game_master: the counter is replaced by a stub
// driven from the stimulus sequence below.
module tb_counter_game_master;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] seed_val;
   logic [1:0] ctrl_mode;
   logic       auto_mode;
   logic       INIT;
   logic [3:0] initial_val;
   logic [1:0] ctrl;
   logic       WINNER;
   logic       LOSER;
   logic       GAMEOVER;
   logic [1:0] WHO;
   logic       busy;
   logic       done;
   logic [3:0] win_tally;
   logic [3:0] loss_tally;
   logic [3:0] games_won;
   logic [3:0] games_lost;
   logic       proto_err;
   logic [2:0] err_code;

   int checks = 0;
   int errors = 0;

   counter_game_master #(
      .NUM_GAMES(2),
      .MODE_HOLD(8),
      .TIMEOUT  (20),
      .LFSR_SEED(4'b1001)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .seed_val   (seed_val),
      .ctrl_mode  (ctrl_mode),
      .auto_mode  (auto_mode),
      .INIT       (INIT),
      .initial_val(initial_val),
      .ctrl       (ctrl),
      .WINNER     (WINNER),
      .LOSER      (LOSER),
      .GAMEOVER   (GAMEOVER),
      .WHO        (WHO),
      .busy       (busy),
      .done       (done),
      .win_tally  (win_tally),
      .loss_tally (loss_tally),
      .games_won  (games_won),
      .games_lost (games_lost),
      .proto_err  (proto_err),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      WINNER   = 1'b0;
      LOSER    = 1'b0;
      GAMEOVER = 1'b0;
      WHO      = 2'b00;
   endtask

   task automatic do_reset();
      clr_in();
      start = 1'b0;
      rst   = 1'b1;
      tick();
      rst   = 1'b0;
   endtask

   // start pulse -> LOAD cycle checked -> returns one edge into PLAY
   task automatic begin_match(input logic [3:0] s, input logic [1:0] m, input logic a);
      seed_val  = s;
      ctrl_mode = m;
      auto_mode = a;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      seed_val  = ~s;
      ctrl_mode = ~m;
      auto_mode = ~a;
      chk("load_init", INIT, 1);
      chk("load_val", initial_val, s);
      chk("load_busy", busy, 1);
      chk("start_clr_games", games_won, 0);
      chk("start_clr_done", done, 0);
      tick();
      chk("play_init_low", INIT, 0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      seed_val = 4'd0;
      ctrl_mode = 2'b00;
      auto_mode = 1'b0;
      clr_in();
      tick();
      tick();
      rst = 1'b0;
      chk("rst_init", INIT, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ctrl", ctrl, 0);
      chk("rst_ival", initial_val, 0);
      chk("rst_perr", proto_err, 0);
      chk("rst_ecode", err_code, 0);
      chk("rst_won", games_won, 0);

      // Match of two winning games, fixed ctrl 00
      begin_match(4'd0, 2'b00, 1'b0);
      chk("g1_ctrl", ctrl, 0);
      repeat (15) begin
         WINNER = 1'b1;
         tick();
      end
      chk("g1_win15", win_tally, 15);
      chk("g1_loss0", loss_tally, 0);
      tick();
      chk("g1_win_sat", win_tally, 15);
      WINNER = 1'b0;
      GAMEOVER = 1'b1;
      WHO = 2'b10;
      tick();
      clr_in();
      chk("g1_record_busy", busy, 1);
      chk("g1_record_perr", proto_err, 0);
      tick();
      chk("g1_won", games_won, 1);
      chk("g1_tally_clr", win_tally, 0);
      chk("g1_not_done", done, 0);
      chk("g1_no_reinit", INIT, 0);
      chk("g1_busy", busy, 1);
      repeat (14) begin
         WINNER = 1'b1;
         tick();
      end
      GAMEOVER = 1'b1;
      WHO = 2'b10;
      tick();
      clr_in();
      chk("g2_same_cycle_ok", proto_err, 0);
      tick();
      chk("m1_done", done, 1);
      chk("m1_busy", busy, 0);
      chk("m1_won", games_won, 2);
      chk("m1_lost", games_lost, 0);
      chk("m1_ctrl", ctrl, 0);
      tick();
      chk("m1_done_hold", done, 1);

      // Restart from DONE, early GAMEOVER
      begin_match(4'hF, 2'b11, 1'b0);
      chk("m2_ctrl", ctrl, 3);
      repeat (3) begin
         LOSER = 1'b1;
         tick();
      end
      LOSER = 1'b0;
      chk("m2_loss3", loss_tally, 3);
      GAMEOVER = 1'b1;
      WHO = 2'b01;
      tick();
      clr_in();
      chk("early_perr", proto_err, 1);
      chk("early_code", err_code, 2);
      chk("early_busy", busy, 0);
      chk("early_ctrl", ctrl, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("err_ignore_start", INIT, 0);
      tick();
      chk("err_sticky", err_code, 2);

      // Simultaneous pulses, with WHO!=0 in the same cycle: lowest code wins
      do_reset();
      chk("rst2_perr", proto_err, 0);
      chk("rst2_code", err_code, 0);
      begin_match(4'd5, 2'b01, 1'b0);
      WINNER = 1'b1;
      LOSER = 1'b1;
      WHO = 2'b10;
      tick();
      clr_in();
      chk("both_code", err_code, 1);

      // WHO without GAMEOVER
      do_reset();
      begin_match(4'd5, 2'b01, 1'b0);
      WHO = 2'b10;
      tick();
      clr_in();
      chk("who_nogo_code", err_code, 4);

      // WHO mismatch after a full losing tally
      do_reset();
      begin_match(4'd0, 2'b10, 1'b0);
      repeat (15) begin
         LOSER = 1'b1;
         tick();
      end
      LOSER = 1'b0;
      GAMEOVER = 1'b1;
      WHO = 2'b10;
      tick();
      clr_in();
      chk("who_mismatch_code", err_code, 3);

      // Timeout after 20 PLAY cycles
      do_reset();
      begin_match(4'd7, 2'b00, 1'b0);
      repeat (19) tick();
      chk("to_19_perr", proto_err, 0);
      chk("to_19_busy", busy, 1);
      tick();
      chk("to_20_perr", proto_err, 1);
      chk("to_20_code", err_code, 5);

      // Auto mode: 1001 -> 0011 -> 0110 every 8 PLAY cycles
      do_reset();
      begin_match(4'd3, 2'b00, 1'b1);
      chk("auto_c0", ctrl, 1);
      repeat (7) tick();
      chk("auto_c7", ctrl, 1);
      tick();
      chk("auto_c8", ctrl, 3);
      repeat (7) tick();
      chk("auto_c15", ctrl, 3);
      tick();
      chk("auto_c16", ctrl, 2);

      // Reset mid-PLAY
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_init", INIT, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_ctrl", ctrl, 0);
      chk("midrst_done", done, 0);
      chk("midrst_perr", proto_err, 0);
      chk("midrst_win", win_tally, 0);
      begin_match(4'd9, 2'b00, 1'b1);
      chk("rst_lfsr_ctrl", ctrl, 1);
      tick();
      chk("single_init", INIT, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
